// File: rtl/ctx_feed.sv
// ctx_feed: byte FIFO feeding CTX as single-cycle ctx_val pulses with programmable gaps.
// Optional sent_cnt statistics counter is enabled by defining CTX_FEED_STATS_EN.
module ctx_feed #(
    parameter int DEPTH = 8,
    parameter int GAP_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    output logic                       s_ready,
    input  logic                       enable,
    input  logic [GAP_W-1:0]           gap_cfg,
    output logic                       ctx_val,
    output logic [7:0]                 ctx_in,
`ifdef CTX_FEED_STATS_EN
    output logic [15:0]                sent_cnt,
`endif
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] ctr_q, ctr_d;
    logic             val_q, val_d;
    logic [7:0]       in_q, in_d;

    logic full;
    logic push;
    logic pop;
    logic can_issue;
    logic try_issue;

    always_comb begin
        full      = (cnt_q == CW'(DEPTH));
        s_ready   = rst_n && !full;
        push      = s_valid && s_ready;
        can_issue = enable && (cnt_q != '0);
    end

    // try_issue marks the cycles in which the IDLE issue rule applies
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        ctr_d     = ctr_q;
        val_d     = 1'b0;
        in_d      = 8'h00;
        pop       = 1'b0;
        try_issue = 1'b0;
        case (state_q)
            S_IDLE: try_issue = 1'b1;
            S_SEND: begin
                if (gap_q != '0) begin
                    state_d = S_GAP;
                    ctr_d   = gap_q - GAP_W'(1);
                end else begin
                    try_issue = 1'b1;
                end
            end
            S_GAP: begin
                if (ctr_q == '0) begin
                    try_issue = 1'b1;
                end else begin
                    ctr_d = ctr_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (try_issue) begin
            if (can_issue) begin
                pop     = 1'b1;
                val_d   = 1'b1;
                in_d    = mem_q[rd_ptr_q];
                gap_d   = gap_cfg;
                state_d = S_SEND;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is not reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            gap_q    <= '0;
            ctr_q    <= '0;
            val_q    <= 1'b0;
            in_q     <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            ctr_q    <= ctr_d;
            val_q    <= val_d;
            in_q     <= in_d;
        end
    end

    assign ctx_val  = val_q;
    assign ctx_in   = in_q;
    assign fifo_cnt = cnt_q;

`ifdef CTX_FEED_STATS_EN
    logic [15:0] sent_q, sent_d;

    always_comb begin
        sent_d = val_d ? sent_q + 16'd1 : sent_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_q <= 16'h0000;
        end else begin
            sent_q <= sent_d;
        end
    end

    assign sent_cnt = sent_q;
`endif

endmodule

// File: tb/tb_ctx_feed.sv
// Scoreboard bench for ctx_feed: stimulus pushes expected bytes, a monitor pops on ctx_val.
// Define CTX_FEED_STATS_EN to also exercise sent_cnt.
module tb_ctx_feed;

    localparam int DEPTH = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic [7:0]       s_data = 8'h00;
    logic             s_ready;
    logic             enable = 1'b0;
    logic [GAP_W-1:0] gap_cfg = '0;
    logic             ctx_val;
    logic [7:0]       ctx_in;
    logic [3:0]       fifo_cnt;
`ifdef CTX_FEED_STATS_EN
    logic [15:0]      sent_cnt;
    logic [15:0]      exp_sent = 16'h0000;
    bit               stats_on = 1'b0;
`endif

    ctx_feed #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .enable   (enable),
        .gap_cfg  (gap_cfg),
        .ctx_val  (ctx_val),
        .ctx_in   (ctx_in),
`ifdef CTX_FEED_STATS_EN
        .sent_cnt (sent_cnt),
`endif
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_q [$];
    int         issue_cyc [$];
    logic [7:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (ctx_val === 1'b1) begin
                issue_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got %h expected none (cycle %0d)", ctx_in, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("ctx_in", {24'h0, ctx_in}, {24'h0, mon_exp});
                end
`ifdef CTX_FEED_STATS_EN
                if (stats_on) begin
                    check("sent_cnt", {16'h0, sent_cnt}, {16'h0, exp_sent});
                    exp_sent = exp_sent + 16'd1;
                end
`endif
            end else begin
                check("idle_out", {23'h0, ctx_val, ctx_in}, 32'h0);
            end
        end
    end

    task automatic push(input logic [7:0] d, output bit acc, output int pcyc);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        acc     = s_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(d);
        #1;
        pcyc = cyc;
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_issues(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (issue_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, issue_cyc.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int pc;
        int nacc;
        int nref;
        int nbad;

        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_val", ctx_val, 0);
        check("rst_in", ctx_in, 0);
        check("rst_cnt", fifo_cnt, 0);
`ifdef CTX_FEED_STATS_EN
        check("rst_sent", sent_cnt, 0);
`endif
        rst_n = 1'b1;

        // single byte latency
        enable  = 1'b1;
        gap_cfg = 4'd0;
        issue_cyc.delete();
        push(8'hA5, acc, pc);
        check("t1_acc", acc, 1);
        idle_in();
        wait_issues(1, 10, "t1_issue");
        if (issue_cyc.size() > 0) check("t1_lat", issue_cyc[0] - pc, 1);
        check("t1_cnt", fifo_cnt, 0);
        @(negedge clk);
        check("t1_pulse", ctx_val, 0);

        // fill to full with enable low, then drain back-to-back
        enable = 1'b0;
        issue_cyc.delete();
        nacc = 0;
        for (int i = 1; i <= 8; i++) begin
            push(8'(i), acc, pc);
            nacc += int'(acc);
        end
        check("t2_acc", nacc, 8);
        push(8'h09, acc, pc);
        check("t2_refuse", acc, 0);
        check("t2_full_cnt", fifo_cnt, 8);
        check("t2_full_rdy", s_ready, 0);
        idle_in();
        enable  = 1'b1;
        gap_cfg = 4'd0;
        wait_issues(8, 20, "t2_issues");
        nbad = 0;
        for (int i = 1; i < issue_cyc.size(); i++)
            if (issue_cyc[i] - issue_cyc[i-1] != 1) nbad++;
        check("t2_b2b", nbad, 0);

        // gap spacing, gap_cfg changed mid-gap
        @(negedge clk);
        enable  = 1'b0;
        gap_cfg = 4'd3;
        issue_cyc.delete();
        push(8'h11, acc, pc);
        push(8'h22, acc, pc);
        push(8'h33, acc, pc);
        idle_in();
        enable = 1'b1;
        wait_issues(1, 10, "t3_first");
        @(negedge clk);
        @(negedge clk);
        gap_cfg = 4'd1;
        wait_issues(3, 20, "t3_issues");
        if (issue_cyc.size() >= 3) begin
            check("t3_gap3", issue_cyc[1] - issue_cyc[0], 4);
            check("t3_gap1", issue_cyc[2] - issue_cyc[1], 2);
        end
        gap_cfg = 4'd0;
        repeat (4) @(negedge clk);

        // full FIFO with s_valid held while draining
        enable = 1'b0;
        issue_cyc.delete();
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), acc, pc);
        enable = 1'b1;
        nref = 0;
        for (int i = 8; i < 12; i++) begin
            int tries;
            tries = 0;
            do begin
                push(8'h40 + 8'(i), acc, pc);
                tries++;
                if (!acc) nref++;
            end while (!acc && tries < 5);
        end
        idle_in();
        check("t4_refused", nref, 1);
        wait_issues(12, 40, "t4_issues");
        nbad = 0;
        for (int i = 1; i < issue_cyc.size(); i++)
            if (issue_cyc[i] - issue_cyc[i-1] != 1) nbad++;
        check("t4_b2b", nbad, 0);
        @(negedge clk);
        check("t4_cnt", fifo_cnt, 0);

        // reset during a gap with bytes queued
        enable  = 1'b0;
        gap_cfg = 4'd5;
        issue_cyc.delete();
        for (int i = 0; i < 5; i++) push(8'h51 + 8'(i), acc, pc);
        idle_in();
        enable = 1'b1;
        wait_issues(1, 10, "t5_first");
        @(negedge clk);
        check("t5_pre_cnt", fifo_cnt, 4);
        rst_n = 1'b0;
        #1;
        check("t5_val", ctx_val, 0);
        check("t5_in", ctx_in, 0);
        check("t5_cnt", fifo_cnt, 0);
        check("t5_rdy", s_ready, 0);
        exp_q.delete();
        issue_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_stale", issue_cyc.size(), 0);
        gap_cfg = 4'd0;
        push(8'h66, acc, pc);
        idle_in();
        wait_issues(1, 10, "t5_recover");

`ifdef CTX_FEED_STATS_EN
        // sent_cnt wrap
        @(negedge clk);
        enable = 1'b0;
        force dut.sent_q = 16'hFFFE;
        @(negedge clk);
        release dut.sent_q;
        @(negedge clk);
        check("t6_preload", sent_cnt, 16'hFFFE);
        exp_sent = 16'hFFFF;
        stats_on = 1'b1;
        issue_cyc.delete();
        push(8'h71, acc, pc);
        push(8'h72, acc, pc);
        push(8'h73, acc, pc);
        idle_in();
        enable = 1'b1;
        wait_issues(3, 20, "t6_issues");
        check("t6_final", sent_cnt, 16'h0001);
`endif

        repeat (3) @(negedge clk);
        check("end_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
